request_latch_8: RTL and testbench
==================================

# request_latch_8

Upstream front end for the 8-to-3 priority encoder. It synchronises and debounces eight raw request lines and latches each debounced rising edge as a sticky pending bit. It drives the encoder's `a[7:0]` and `enable` inputs. The consumer clears a pending bit by acknowledging the 3-bit code the encoder produced, so the next-lowest pending request then reaches the encoder.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles needed to accept a level change; legal range 1..255.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `key_in`  input  8  raw asynchronous request lines, active high.
- `ack`  input  1  acknowledge strobe, one cycle per acknowledge.
- `ack_code`  input  3  index of the pending bit to clear; valid when `ack`=1.
- `a`  output  8  registered pending vector, fed directly to the encoder's `a`.
- `enable`  output  1  OR of `a`; combinational from the `a` register, so it changes on the same edge as `a`.

## Operation
- Per line i, in order:
  - Two-flop synchroniser: `key_in[i]` → `s1[i]` → `s2[i]`.
  - Debounce: register `stable[i]` plus an 8-bit counter `cnt[i]`.
- Debounce rules, per line:
  - `s2`==`stable`: `cnt` ← 0.
  - `s2`!=`stable` and `cnt` < `DEBOUNCE_CYCLES`-1: `cnt` ← `cnt`+1.
  - `s2`!=`stable` and `cnt` == `DEBOUNCE_CYCLES`-1: `stable` ← `s2`, `cnt` ← 0.
- A glitch at `s2` shorter than `DEBOUNCE_CYCLES` cycles leaves `stable` unchanged and returns `cnt` to 0.
- Rising-edge event: on the edge where `stable[i]` goes 0→1, `a[i]` ← 1.
- Falling edges update `stable` only; they never change `a`.
- Clear: `ack`=1 clears `a[ack_code]` at the next edge.
- Simultaneous set and clear of the same bit in one cycle: set wins, so the new event is kept.
- Ack of a bit that is already 0: no effect on any state.
- `ack`=0: `ack_code` is ignored.
- Sets and the clear are independent per bit; several bits may set in the same cycle as an unrelated clear.
- `a[i]` stays set while `key_in[i]` is still held. A line held high after its ack does not re-set; it needs a full release (debounced low) and a new press.
- `ack_code` wider than the vector cannot occur (3 bits index 8 lines); no out-of-range handling.

## Timing
- Reset (`rst_n`=0, asynchronous): `s1`, `s2`, `stable`, `cnt`, `a` all cleared; `a`=8'h00, `enable`=0 immediately, with no clock needed.
- Reset mid-operation: all pending events and any debounce in progress are discarded.
- Lines high at reset release: `stable` restarts from 0, so each such line produces one event after the normal debounce latency.
- Latency: let edge k be the first edge at which `s1[i]` captures 1, with `key_in` held. Then:
  - `s2[i]`=1 after edge k+1.
  - `stable[i]` and `a[i]` = 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `DEBOUNCE_CYCLES`=4: `a[i]` visible after edge k+5.
- `DEBOUNCE_CYCLES`=1: `stable` follows `s2` with one cycle of delay; no filtering.
- Ack latency: `a` bit cleared, and `enable` updated, after the edge that samples `ack`=1.
- Round trip: the encoder output is combinational on `a`, so the consumer may assert `ack` in the cycle after it sees a code. A back-to-back ack every cycle drains one bit per cycle.

## Test plan
- Reset: hold `rst_n`=0 with `key_in`=8'hFF → `a`=8'h00, `enable`=0. Release with `key_in` still high → `a`=8'hFF exactly 1+`DEBOUNCE_CYCLES` edges after the first `s1` capture.
- Debounce, `DEBOUNCE_CYCLES`=4: pulse `key_in[3]` high for 3 cycles → `a` stays 8'h00. Hold it for 4+ cycles → `a`=8'h08 at edge k+5.
- Sticky and ack: set `a`=8'h0A, then `ack`=1, `ack_code`=3'd1 → `a`=8'h08. Next `ack_code`=3'd3 → `a`=8'h00, `enable`=0.
- Set/clear collision: arrange the debounced rise of line 5 on the same edge as `ack`=1, `ack_code`=3'd5 with `a[5]` already 1 → `a[5]` remains 1.
- No re-trigger: hold `key_in[0]` high, ack code 0 → `a[0]`=0 and stays 0. Release for ≥`DEBOUNCE_CYCLES`+2 cycles, then press again → `a[0]`=1.
- Async reset mid-debounce: drop `rst_n` between clock edges while `cnt[2]`=2 and `a`=8'h10 → `a`=8'h00 immediately, and `cnt` restarts after release.

Source files
------------

// File: rtl/request_latch_8.sv
// Front end for the 8-to-3 priority encoder: synchronises and debounces eight
// request lines and holds each debounced rising edge as a sticky pending bit.
module request_latch_8 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_in,
    input  logic       ack,
    input  logic [2:0] ack_code,
    output logic [7:0] a,
    output logic       enable
);

    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]            s1;
    logic [N-1:0]            s2;
    logic [N-1:0]            stable;
    logic [N-1:0]            stable_nxt;
    logic [N-1:0]            rise;
    logic [N-1:0]            a_nxt;
    logic [N-1:0][CNT_W-1:0] cnt;
    logic [N-1:0][CNT_W-1:0] cnt_nxt;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_nxt & ~stable;

    // Set is applied after the clear so a new event survives a same-cycle ack.
    always_comb begin
        a_nxt = a;
        if (ack) begin
            a_nxt[ack_code] = 1'b0;
        end
        a_nxt = a_nxt | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            cnt    <= '0;
            a      <= '0;
        end else begin
            s1     <= key_in;
            s2     <= s1;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            a      <= a_nxt;
        end
    end

    assign enable = |a;

endmodule

// File: tb/tb_request_latch_8.sv
// Bench for request_latch_8: directed vector table, hand-written corner
// sequences and randomized traffic against an event-level reference model.
module tb_request_latch_8;

    localparam int unsigned D = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_in;
    logic       ack;
    logic [2:0] ack_code;
    logic [7:0] a;
    logic       enable;

    int checks = 0;
    int errors = 0;

    request_latch_8 #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .ack      (ack),
        .ack_code (ack_code),
        .a        (a),
        .enable   (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout a=%h", a);
        $fatal(1, "timeout");
    end

    // Reference model: key samples delayed two edges, run-length debounce, pending set.
    logic [7:0] m_sync[$];
    logic [7:0] m_stable;
    int         m_run[8];
    logic [7:0] m_pend;

    task automatic model_reset();
        m_sync.delete();
        m_sync.push_back(8'h00);
        m_sync.push_back(8'h00);
        m_stable = 8'h00;
        m_pend   = 8'h00;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [7:0] seen;
        logic [7:0] rise;
        seen = m_sync[0];
        rise = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (seen[i] != m_stable[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= int'(D)) begin
                    m_stable[i] = seen[i];
                    m_run[i]    = 0;
                    if (seen[i]) rise[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_sync.delete(0);
        m_sync.push_back(key_in);
        if (ack) m_pend[ack_code] = 1'b0;
        m_pend = m_pend | rise;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock edge: advance the model, then compare a and enable just after the edge.
    task automatic tick();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        check("model_a", a, m_pend);
        check("model_enable", {7'b0, enable}, {7'b0, |m_pend});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic [7:0] key;
        logic       ack;
        logic [2:0] code;
        logic [7:0] exp_a;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst_n    = 1'b0;
        key_in   = 8'hFF;
        ack      = 1'b0;
        ack_code = 3'd0;
        model_reset();

        // Reset with all lines high, then release between edges.
        #2;
        check("reset_a", a, 8'h00);
        check("reset_enable", {7'b0, enable}, 8'h00);
        ticks(3);
        check("reset_held_a", a, 8'h00);
        #3 rst_n = 1'b1;
        ticks(5);
        check("release_before_latency", a, 8'h00);
        tick();
        check("release_latency", a, 8'hFF);
        key_in = 8'h00;
        ack    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ack_code = 3'(i);
            tick();
        end
        ack = 1'b0;
        check("drain_all", a, 8'h00);
        ticks(8);

        // Directed vector table from a quiet state.
        for (int i = 0; i < 5; i++) vecs[i] = '{8'h0A, 1'b0, 3'd0, 8'h00};
        vecs[5]  = '{8'h0A, 1'b0, 3'd0, 8'h0A};
        vecs[6]  = '{8'h0A, 1'b1, 3'd1, 8'h08};
        vecs[7]  = '{8'h0A, 1'b1, 3'd3, 8'h00};
        vecs[8]  = '{8'h0A, 1'b1, 3'd5, 8'h00};
        vecs[9]  = '{8'h0A, 1'b0, 3'd7, 8'h00};
        vecs[10] = '{8'h00, 1'b0, 3'd1, 8'h00};
        vecs[11] = '{8'h00, 1'b1, 3'd2, 8'h00};
        for (int i = 0; i < 12; i++) begin
            key_in   = vecs[i].key;
            ack      = vecs[i].ack;
            ack_code = vecs[i].code;
            tick();
            check($sformatf("vec%0d_a", i), a, vecs[i].exp_a);
            check($sformatf("vec%0d_en", i), {7'b0, enable}, {7'b0, |vecs[i].exp_a});
        end
        ack = 1'b0;
        ticks(8);

        // Glitches of 3 cycles are filtered; a 4-cycle hold is accepted at edge k+5.
        key_in = 8'h08;
        ticks(3);
        key_in = 8'h00;
        ticks(10);
        check("glitch_filtered", a, 8'h00);
        key_in = 8'h08;
        ticks(5);
        check("hold_before_k5", a, 8'h00);
        tick();
        check("hold_at_k5", a, 8'h08);
        key_in   = 8'h00;
        ack      = 1'b1;
        ack_code = 3'd3;
        tick();
        ack = 1'b0;
        ticks(8);

        // No re-trigger while held; a release and fresh press sets again.
        key_in = 8'h01;
        ticks(6);
        check("press0", a, 8'h01);
        ack      = 1'b1;
        ack_code = 3'd0;
        tick();
        ack = 1'b0;
        ticks(12);
        check("held_no_retrigger", a, 8'h00);
        key_in = 8'h00;
        ticks(D + 2);
        key_in = 8'h01;
        ticks(6);
        check("repress0", a, 8'h01);
        key_in   = 8'h00;
        ack      = 1'b1;
        tick();
        ack = 1'b0;
        ticks(8);

        // Set/clear collision on line 5: the new rise wins over the ack.
        key_in = 8'h20;
        ticks(6);
        check("coll_first_set", a, 8'h20);
        key_in = 8'h00;
        ticks(D + 4);
        check("coll_after_release", a, 8'h20);
        key_in = 8'h20;
        ticks(5);
        ack      = 1'b1;
        ack_code = 3'd5;
        tick();
        ack = 1'b0;
        check("coll_set_wins", a, 8'h20);
        ack = 1'b1;
        tick();
        ack    = 1'b0;
        key_in = 8'h00;
        check("coll_cleared", a, 8'h00);
        ticks(8);

        // Asynchronous reset mid-debounce discards pending bits and the count in progress.
        key_in = 8'h10;
        ticks(6);
        key_in = 8'h14;
        ticks(4);
        check("pre_reset_a", a, 8'h10);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", a, 8'h00);
        check("async_reset_en", {7'b0, enable}, 8'h00);
        model_reset();
        #2 rst_n = 1'b1;
        ticks(5);
        check("restart_before", a, 8'h00);
        tick();
        check("restart_event", a, 8'h14);
        key_in   = 8'h00;
        ack      = 1'b1;
        ack_code = 3'd2;
        tick();
        ack_code = 3'd4;
        tick();
        ack = 1'b0;
        ticks(8);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 6) == 0) key_in[i] = ~key_in[i];
            end
            ack      = ($urandom_range(0, 2) == 0);
            ack_code = 3'($urandom_range(0, 7));
            tick();
        end
        ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
